// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and constants for the memory access stage
// Contents:
//   state_e    FSM state encoding (IDLE=0, REQ=1, WAIT=2, DONE=3)
//   BE_WORD    byte-enable pattern for a full-word access
//   TIMEOUT_W  width of the access timeout counter
//   lane_be()  one-hot byte enable for byte lane k
package mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [3:0] BE_WORD   = 4'hF;
    localparam int         TIMEOUT_W = 8;

    function automatic logic [3:0] lane_be(input logic [1:0] k);
        return 4'b0001 << k;
    endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// rtl/byte_lane_unit.sv - combinational byte-lane steering for stores and loads
// Ports:
//   is_byte_i  1 = byte access, 0 = word access
//   st_lane_i  byte lane of the store address
//   wdata_i    store word
//   wbyte_i    store byte
//   ld_lane_i  byte lane of the load address
//   rdata_i    load word from memory
//   be_o       store byte enables
//   wdata_o    store data on the bus (byte replicated to all lanes)
//   rbyte_o    selected byte of the load word
module byte_lane_unit
    import mem_stage_pkg::*;
(
    input  logic        is_byte_i,
    input  logic [1:0]  st_lane_i,
    input  logic [31:0] wdata_i,
    input  logic [7:0]  wbyte_i,
    input  logic [1:0]  ld_lane_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [7:0]  rbyte_o
);

    assign be_o    = is_byte_i ? lane_be(st_lane_i) : BE_WORD;
    assign wdata_o = is_byte_i ? {4{wbyte_i}} : wdata_i;
    assign rbyte_o = rdata_i[8*ld_lane_i +: 8];

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - load/store stage with req/gnt/rvalid memory port and pipeline stall
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   ex_valid, mem_rd, mem_wr         EX/MEM op; rd&wr is handled as a load
//   mem_byte, addr, wdata, wbyte     access size, byte address, store data
//   stall                            hold the front of the pipeline
//   Do_Out, Dob_Out, PROHIB_MEM      registered load results and writeback cancel
//   m_req, m_we, m_addr, m_be, m_wdata, m_gnt, m_rvalid, m_rdata   data-memory port
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic              mem_byte,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [7:0]        wbyte,
    output logic              stall,
    output logic [31:0]       Do_Out,
    output logic [7:0]        Dob_Out,
    output logic              PROHIB_MEM,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [3:0]        m_be,
    output logic [31:0]       m_wdata,
    input  logic              m_gnt,
    input  logic              m_rvalid,
    input  logic [31:0]       m_rdata
);

    // Counter value seen during the last permitted REQ/WAIT cycle.
    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT - 1);

    state_e               state_q;
    logic [TIMEOUT_W-1:0] cnt_q;
    logic                 we_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [1:0]           lane_q;
    logic [3:0]           be_q;
    logic [31:0]          wdata_q;
    logic [31:0]          do_q;
    logic [7:0]           dob_q;
    logic                 prohib_q;

    logic                 accept;
    logic                 misaligned;
    logic                 timeout_hit;
    logic [TIMEOUT_W-1:0] cnt_inc;
    logic [3:0]           blu_be;
    logic [31:0]          blu_wdata;
    logic [7:0]           blu_rbyte;

    assign accept      = ex_valid & (mem_rd | mem_wr);
    assign misaligned  = ~mem_byte & (addr[1:0] != 2'b00);
    assign timeout_hit = (cnt_q >= TO_LAST);
    assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    byte_lane_unit u_lanes (
        .is_byte_i (mem_byte),
        .st_lane_i (addr[1:0]),
        .wdata_i   (wdata),
        .wbyte_i   (wbyte),
        .ld_lane_i (lane_q),
        .rdata_i   (m_rdata),
        .be_o      (blu_be),
        .wdata_o   (blu_wdata),
        .rbyte_o   (blu_rbyte)
    );

    // The accept-cycle stall is combinational so EX/MEM holds on the very first
    // cycle; it is gated by rst_n so an asserted reset silences it at once.
    assign stall = rst_n & (((state_q == ST_IDLE) & accept) |
                            (state_q == ST_REQ) | (state_q == ST_WAIT));

    assign m_req      = (state_q == ST_REQ);
    assign m_we       = m_req & we_q;
    assign m_addr     = addr_q;
    assign m_be       = be_q;
    assign m_wdata    = wdata_q;
    assign Do_Out     = do_q;
    assign Dob_Out    = dob_q;
    assign PROHIB_MEM = prohib_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            lane_q   <= 2'b00;
            be_q     <= 4'h0;
            wdata_q  <= 32'h0;
            do_q     <= 32'h0;
            dob_q    <= 8'h0;
            prohib_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        cnt_q    <= '0;
                        prohib_q <= misaligned;
                        if (misaligned) begin
                            state_q <= ST_DONE;
                        end else begin
                            we_q    <= mem_wr & ~mem_rd;
                            addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                            lane_q  <= addr[1:0];
                            be_q    <= blu_be;
                            wdata_q <= blu_wdata;
                            state_q <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    cnt_q <= cnt_inc;
                    // A completion in the last permitted cycle beats the timeout.
                    if (m_gnt && we_q) begin
                        state_q <= ST_DONE;
                    end else if (m_gnt && m_rvalid) begin
                        do_q    <= m_rdata;
                        dob_q   <= blu_rbyte;
                        state_q <= ST_DONE;
                    end else if (timeout_hit) begin
                        do_q     <= 32'h0;
                        dob_q    <= 8'h0;
                        prohib_q <= 1'b1;
                        state_q  <= ST_DONE;
                    end else if (m_gnt) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_inc;
                    if (m_rvalid) begin
                        do_q    <= m_rdata;
                        dob_q   <= blu_rbyte;
                        state_q <= ST_DONE;
                    end else if (timeout_hit) begin
                        do_q     <= 32'h0;
                        dob_q    <= 8'h0;
                        prohib_q <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                default: begin
                    // DONE: results were visible for this cycle; the old op in
                    // EX/MEM is never re-accepted from here.
                    prohib_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, mem_rd, mem_wr, mem_byte;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [7:0]  wbyte;
    logic        stall;
    logic [31:0] Do_Out;
    logic [7:0]  Dob_Out;
    logic        PROHIB_MEM;
    logic        m_req, m_we;
    logic [15:0] m_addr;
    logic [3:0]  m_be;
    logic [31:0] m_wdata;
    logic        m_gnt, m_rvalid;
    logic [31:0] m_rdata;

    mem_access_stage #(.ADDR_W(16), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_byte(mem_byte), .addr(addr), .wdata(wdata), .wbyte(wbyte), .stall(stall),
        .Do_Out(Do_Out), .Dob_Out(Dob_Out), .PROHIB_MEM(PROHIB_MEM), .m_req(m_req),
        .m_we(m_we), .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata), .m_gnt(m_gnt),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    // Model expectations, written only by the stimulus process.
    logic        exp_stall = 0, exp_req = 0, exp_we = 0, exp_prohib = 0;
    logic [15:0] exp_addr = 0;
    logic [3:0]  exp_be = 0;
    logic [31:0] exp_wdata = 0, exp_do = 0;
    logic [7:0]  exp_dob = 0;

    // Literal pins handed to the compare process.
    string       pin_name = "";
    logic [31:0] pin_act = 0, pin_exp = 0;
    int          pin_seq = 0;

    // Owned by the compare process.
    int          total = 0, bad = 0, stall_seen = 0, pin_done = 0;

    // Observations recorded by the stimulus process.
    int          stalls;
    logic        d_prohib, r_we;
    logic [15:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;

    function automatic int chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
            return 1;
        end
        return 0;
    endfunction

    always @(negedge clk) begin
        int t, b;
        t = 0;
        b = 0;
        b += chk("stall", 32'(stall), 32'(exp_stall));        t++;
        b += chk("m_req", 32'(m_req), 32'(exp_req));          t++;
        b += chk("Do_Out", Do_Out, exp_do);                   t++;
        b += chk("Dob_Out", 32'(Dob_Out), 32'(exp_dob));      t++;
        b += chk("PROHIB_MEM", 32'(PROHIB_MEM), 32'(exp_prohib)); t++;
        if (!rst_n) begin
            b += chk("rst m_we", 32'(m_we), 0);               t++;
            b += chk("rst m_addr", 32'(m_addr), 0);           t++;
            b += chk("rst m_be", 32'(m_be), 0);               t++;
            b += chk("rst m_wdata", m_wdata, 0);              t++;
        end else if (exp_req) begin
            b += chk("m_we", 32'(m_we), 32'(exp_we));         t++;
            b += chk("m_addr", 32'(m_addr), 32'(exp_addr));   t++;
            if (exp_we) begin
                b += chk("m_be", 32'(m_be), 32'(exp_be));     t++;
                b += chk("m_wdata", m_wdata, exp_wdata);      t++;
            end
        end
        if (pin_seq != pin_done) begin
            b += chk(pin_name, pin_act, pin_exp);             t++;
            pin_done <= pin_seq;
        end
        if (stall) stall_seen <= stall_seen + 1;
        total <= total + t;
        bad   <= bad + b;
    end

    task automatic pin(input string nm, input logic [31:0] act, input logic [31:0] exp);
        pin_name = nm;
        pin_act  = act;
        pin_exp  = exp;
        pin_seq++;
        @(negedge clk);
        #1;
    endtask

    task automatic resync();
        @(posedge clk);
        #1;
    endtask

    // One memory op from accept through DONE. gnt_at/rv_at are cycle indices
    // counted from the first request cycle; -1 means never.
    task automatic run_op(input logic rd, input logic wr, input logic byt, input logic [15:0] a,
                          input logic [31:0] wd, input logic [7:0] wb,
                          input int gnt_at, input int rv_at, input logic [31:0] rdat);
        logic is_wr, mis, tout;
        int   k, c_end, n, start;
        is_wr = wr & ~rd;
        mis   = ~byt & (a[1:0] != 2'b00);
        k     = int'(a[1:0]);
        tout  = 1'b0;
        ex_valid = 1; mem_rd = rd; mem_wr = wr; mem_byte = byt; addr = a;
        wdata = wd; wbyte = wb; m_gnt = 0; m_rvalid = 0; m_rdata = rdat;
        exp_stall = 1; exp_req = 0; exp_prohib = 0;
        exp_we    = is_wr;
        exp_addr  = {a[15:2], 2'b00};
        exp_be    = byt ? (4'b0001 << k) : 4'hF;
        exp_wdata = byt ? {4{wb}} : wd;
        r_we = 0; r_addr = 0; r_be = 0; r_wdata = 0;
        start = stall_seen;
        resync();
        if (!mis) begin
            c_end = is_wr ? gnt_at : rv_at;
            tout  = (c_end < 0) || (c_end >= TO);
            n     = tout ? TO : c_end + 1;
            for (int c = 0; c < n; c++) begin
                exp_req  = (gnt_at < 0) || (c <= gnt_at);
                m_gnt    = (c == gnt_at);
                m_rvalid = !is_wr && (c == rv_at);
                @(negedge clk);
                if (exp_req) begin
                    r_we = m_we; r_addr = m_addr; r_be = m_be; r_wdata = m_wdata;
                end
                resync();
            end
            m_gnt = 0; m_rvalid = 0; exp_req = 0;
            if (tout) begin
                exp_do = 0; exp_dob = 0;
            end else if (!is_wr) begin
                exp_do = rdat; exp_dob = rdat[8*k +: 8];
            end
        end
        exp_stall  = 0;
        exp_prohib = mis | tout;
        @(negedge clk);
        d_prohib = PROHIB_MEM;
        resync();
        ex_valid = 0; mem_rd = 0; mem_wr = 0; exp_prohib = 0;
        stalls = stall_seen - start;
    endtask

    task automatic idle(input int n, input logic ev, input logic g, input logic rv, input logic [31:0] rd);
        ex_valid = ev; mem_rd = 0; mem_wr = 0; m_gnt = g; m_rvalid = rv; m_rdata = rd;
        exp_stall = 0; exp_req = 0; exp_prohib = 0;
        repeat (n) resync();
        ex_valid = 0; m_gnt = 0; m_rvalid = 0;
    endtask

    initial begin
        rst_n = 0; ex_valid = 0; mem_rd = 0; mem_wr = 0; mem_byte = 0; addr = 0;
        wdata = 0; wbyte = 0; m_gnt = 0; m_rvalid = 0; m_rdata = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        idle(2, 0, 0, 0, 0);

        // Word load, gnt in first request cycle, rvalid two cycles later.
        run_op(1, 0, 0, 16'h0010, 0, 0, 0, 2, 32'hA1B2C3D4);
        pin("t2 stalls", stalls, 4);
        pin("t2 Do_Out", Do_Out, 32'hA1B2C3D4);
        pin("t2 prohib", 32'(d_prohib), 0);
        resync();

        // Byte load lane 3, gnt and rvalid together.
        run_op(1, 0, 1, 16'h0013, 0, 0, 0, 0, 32'hA1B2C3D4);
        pin("t3 Dob_Out", 32'(Dob_Out), 32'hA1);
        pin("t3 stalls", stalls, 2);
        resync();

        // Byte store lane 1, gnt after one wait cycle.
        run_op(0, 1, 1, 16'h0021, 32'h0, 8'h5A, 1, -1, 0);
        pin("t4 m_addr", 32'(r_addr), 32'h0020);
        pin("t4 m_be", 32'(r_be), 32'h2);
        pin("t4 m_wdata", r_wdata, 32'h5A5A5A5A);
        pin("t4 m_we", 32'(r_we), 1);
        pin("t4 Do kept", Do_Out, 32'hA1B2C3D4);
        resync();

        // Word store, then a non-memory op and stray handshakes.
        run_op(0, 1, 0, 16'h0104, 32'hDEADBEEF, 0, 0, -1, 0);
        idle(3, 1, 1, 1, 32'h12345678);

        // Misaligned word load and store.
        run_op(1, 0, 0, 16'h0002, 0, 0, 0, 0, 32'hFFFFFFFF);
        pin("t5 stalls", stalls, 1);
        pin("t5 prohib", 32'(d_prohib), 1);
        resync();
        run_op(0, 1, 0, 16'h0003, 32'h11111111, 0, 0, -1, 0);

        // Byte load lane 1; rd&wr together behaves as a load finishing on the last allowed cycle.
        run_op(1, 0, 1, 16'h0041, 0, 0, 0, 1, 32'h11223344);
        run_op(1, 1, 1, 16'h0052, 32'h0, 8'h77, 2, 3, 32'hCAFEF00D);
        pin("rdwr Dob_Out", 32'(Dob_Out), 32'hFE);
        pin("rdwr prohib", 32'(d_prohib), 0);
        resync();

        // Read timeout after grant, then a late rvalid that must be ignored.
        run_op(1, 0, 0, 16'h0080, 0, 0, 0, -1, 32'h55555555);
        pin("t6 stalls", stalls, 5);
        pin("t6 prohib", 32'(d_prohib), 1);
        pin("t6 Do_Out", Do_Out, 0);
        resync();
        idle(2, 0, 0, 1, 32'h99999999);

        // Store never granted: request held for the whole budget, then dropped.
        run_op(0, 1, 0, 16'h0090, 32'h0BADF00D, 0, -1, -1, 0);
        pin("nogrant prohib", 32'(d_prohib), 1);
        resync();

        // Load to set Do_Out, then reset in the middle of the next request.
        run_op(1, 0, 0, 16'h00A8, 0, 0, 0, 0, 32'h87654321);
        ex_valid = 1; mem_rd = 1; mem_byte = 0; addr = 16'h0030; m_rdata = 0;
        exp_stall = 1; exp_req = 0; exp_we = 0; exp_addr = 16'h0030;
        resync();
        exp_req = 1;
        @(negedge clk);
        #1;
        rst_n = 0;
        exp_stall = 0; exp_req = 0; exp_do = 0; exp_dob = 0; exp_prohib = 0;
        #1;
        pin("rst m_req now", 32'(m_req), 0);
        ex_valid = 0; mem_rd = 0;
        resync();
        rst_n = 1;
        idle(1, 0, 0, 0, 0);

        // Recovery after reset.
        run_op(1, 0, 1, 16'h0032, 0, 0, 0, 1, 32'h0A0B0C0D);
        pin("post-rst Dob_Out", 32'(Dob_Out), 32'h0B);
        idle(2, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
